// File: rtl/counter_seq_pkg.sv
// Shared types and default sizes for the counter sequencer.
package counter_seq_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_STEP_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_UP    = 2'd1,
    OP_DOWN  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/counter_sequencer.sv
// Command-driven controller for an up/down counter: load, clear and step bursts
// with optional stop-at-boundary saturation and a one-cycle done pulse.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_sat_en,
  input  logic              max_count,
  input  logic              zero,
  output logic              load_n,
  output logic              ce,
  output logic              up_down,
  output logic [WIDTH-1:0]  data_load,
  output logic              busy,
  output logic              done,
  output logic              sat
);

  state_e             state, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic               sat_en_q, sat_en_d;
  logic               sat_q, sat_d;
  logic               boundary;

  // State and command latch registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_LOAD;
      data_q   <= '0;
      steps_q  <= '0;
      sat_en_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state    <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      steps_q  <= steps_d;
      sat_en_q <= sat_en_d;
      sat_q    <= sat_d;
    end
  end

  // Next-state and counter drive; ce depends on the counter flags only through
  // the count register, so there is no combinational loop.
  always_comb begin
    state_d   = state;
    op_d      = op_q;
    data_d    = data_q;
    steps_d   = steps_q;
    sat_en_d  = sat_en_q;
    sat_d     = sat_q;
    load_n    = 1'b1;
    ce        = 1'b0;
    up_down   = 1'b0;
    data_load = '0;
    boundary  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d     = op_e'(cmd_op);
          data_d   = cmd_data;
          steps_d  = cmd_steps;
          sat_en_d = cmd_sat_en;
          sat_d    = 1'b0;
          case (op_e'(cmd_op))
            OP_LOAD, OP_CLEAR: state_d = ST_LOAD;
            default:           state_d = (cmd_steps == '0) ? ST_DONE : ST_RUN;
          endcase
        end
      end

      ST_LOAD: begin
        load_n    = 1'b0;
        data_load = (op_q == OP_LOAD) ? data_q : '0;
        state_d   = ST_DONE;
      end

      ST_RUN: begin
        up_down  = (op_q == OP_UP);
        boundary = (op_q == OP_UP) ? max_count : zero;
        ce       = !(sat_en_q && boundary);
        if (ce) begin
          steps_d = steps_q - STEP_W'(1);
          if (steps_q == STEP_W'(1)) begin
            state_d = ST_DONE;
            sat_d   = 1'b0;
          end
        end else begin
          state_d = ST_DONE;
          sat_d   = 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign sat       = (state == ST_DONE) && sat_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed and soak bench pairing counter_sequencer with a behavioural 4-bit
// up/down counter; expected values come from hand-computed tables and a model.
module tb_counter_sequencer;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned STEP_W = 8;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [WIDTH-1:0]  cmd_data;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_sat_en;
  logic              max_count;
  logic              zero;
  logic              load_n;
  logic              ce;
  logic              up_down;
  logic [WIDTH-1:0]  data_load;
  logic              busy;
  logic              done;
  logic              sat;
  logic [WIDTH-1:0]  cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int acc_cnt = 0;

  counter_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_steps(cmd_steps), .cmd_sat_en(cmd_sat_en),
    .max_count(max_count), .zero(zero),
    .load_n(load_n), .ce(ce), .up_down(up_down), .data_load(data_load),
    .busy(busy), .done(done), .sat(sat)
  );

  // Attached counter: load has priority over count enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (!load_n) cnt <= data_load;
    else if (ce)      cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
  end
  assign max_count = (cnt == 4'hF);
  assign zero      = (cnt == 4'h0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [7:0] steps;
    logic       sat_en;
    logic [3:0] cnt;
    int         ce_n;
    int         ld_n;
    int         done_cyc;
    logic       sat;
    logic [3:0] dl;
  } vec_t;

  function automatic vec_t mk(logic [1:0] op, logic [3:0] data, logic [7:0] steps,
                              logic sat_en, logic [3:0] c, int ce_n, int ld_n,
                              int done_cyc, logic s, logic [3:0] dl);
    vec_t v;
    v.op = op; v.data = data; v.steps = steps; v.sat_en = sat_en; v.cnt = c;
    v.ce_n = ce_n; v.ld_n = ld_n; v.done_cyc = done_cyc; v.sat = s; v.dl = dl;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Independent reference for one command, starting from count c.
  function automatic vec_t model(logic [1:0] op, logic [3:0] data, logic [7:0] steps,
                                 logic sat_en, logic [3:0] c);
    logic [3:0] m = c;
    int         k = 0;
    logic       s = 1'b0;
    if (op == 2'd0) return mk(op, data, steps, sat_en, data, 0, 1, 2, 1'b0, data);
    if (op == 2'd3) return mk(op, data, steps, sat_en, 4'd0, 0, 1, 2, 1'b0, 4'd0);
    if (steps == 8'd0) return mk(op, data, steps, sat_en, c, 0, 0, 1, 1'b0, 4'd0);
    for (int i = 0; i < int'(steps); i++) begin
      if (sat_en && ((op == 2'd1) ? (m == 4'hF) : (m == 4'h0))) begin
        s = 1'b1;
        break;
      end
      m = (op == 2'd1) ? m + 4'd1 : m - 4'd1;
      k++;
    end
    return mk(op, data, steps, sat_en, m, k, 0, s ? k + 2 : k + 1, s, 4'd0);
  endfunction

  // Issue one command and check every observable of the burst.
  task automatic run_cmd(input vec_t v, input int idx);
    int cyc = 1, ce_seen = 0, ld_seen = 0, dl_seen = -1, sat_seen = 0;
    int stray_sat = 0, waited = 0;
    bit got_done = 0;
    while (!cmd_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    check("ready_wait", idx, int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data;
    cmd_steps = v.steps; cmd_sat_en = v.sat_en;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = $urandom_range(0, 3); cmd_data = $urandom_range(0, 15);
    acc_cnt++;
    for (int t = 0; t < 300; t++) begin
      if (ce) ce_seen++;
      if (!load_n) begin ld_seen++; dl_seen = int'(data_load); end
      if (done) begin
        got_done = 1; sat_seen = int'(sat);
        break;
      end
      if (sat) stray_sat++;
      cyc++;
      @(posedge clk); #1;
    end
    check("done_seen", idx, int'(got_done), 1);
    check("done_cycle", idx, cyc, v.done_cyc);
    check("ce_cycles", idx, ce_seen, v.ce_n);
    check("load_cycles", idx, ld_seen, v.ld_n);
    if (v.ld_n > 0) check("data_load", idx, dl_seen, int'(v.dl));
    check("sat", idx, sat_seen, int'(v.sat));
    check("sat_stray", idx, stray_sat, 0);
    @(posedge clk); #1;
    check("ready_back", idx, int'(cmd_ready), 1);
    check("done_pulse", idx, int'(done), 0);
    check("count", idx, int'(cnt), int'(v.cnt));
    check("zero_flag", idx, int'(zero), int'(v.cnt == 4'h0));
  endtask

  vec_t vecs[14];
  logic [3:0] mcnt;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
    cmd_steps = '0; cmd_sat_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 0, int'(cmd_ready), 1);
    check("rst_busy", 0, int'(busy), 0);
    check("rst_done", 0, int'(done), 0);
    check("rst_load_n", 0, int'(load_n), 1);
    check("rst_ce", 0, int'(ce), 0);
    check("rst_data_load", 0, int'(data_load), 0);
    rst = 1'b0;

    // Reset in the middle of an UP 10 burst, during step 4.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_steps = 8'd10; cmd_sat_en = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_ce", 1, int'(ce), 1);
    check("mid_busy", 1, int'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ce", 1, int'(ce), 0);
    check("mid_rst_load_n", 1, int'(load_n), 1);
    check("mid_rst_busy", 1, int'(busy), 0);
    check("mid_rst_ready", 1, int'(cmd_ready), 1);
    check("mid_rst_done", 1, int'(done), 0);
    check("mid_rst_up_down", 1, int'(up_down), 0);
    @(posedge clk); #1;
    check("mid_rst_hold_done", 1, int'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_done", 1, int'(done), 0);
    check("post_rst_count", 1, int'(cnt), 0);

    //          op     data   steps  sat   cnt    ce   ld  done sat   dl
    vecs[0]  = mk(2'd0, 4'hA, 8'd0,   1'b0, 4'd10, 0,   1,  2,   1'b0, 4'd10);
    vecs[1]  = mk(2'd1, 4'h0, 8'd3,   1'b0, 4'd13, 3,   0,  4,   1'b0, 4'd0);
    vecs[2]  = mk(2'd1, 4'h0, 8'd5,   1'b1, 4'd15, 2,   0,  4,   1'b1, 4'd0);
    vecs[3]  = mk(2'd0, 4'hD, 8'd0,   1'b0, 4'd13, 0,   1,  2,   1'b0, 4'd13);
    vecs[4]  = mk(2'd1, 4'h0, 8'd5,   1'b0, 4'd2,  5,   0,  6,   1'b0, 4'd0);
    vecs[5]  = mk(2'd2, 4'h0, 8'd0,   1'b0, 4'd2,  0,   0,  1,   1'b0, 4'd0);
    vecs[6]  = mk(2'd3, 4'h7, 8'd0,   1'b0, 4'd0,  0,   1,  2,   1'b0, 4'd0);
    vecs[7]  = mk(2'd2, 4'h0, 8'd1,   1'b1, 4'd0,  0,   0,  2,   1'b1, 4'd0);
    vecs[8]  = mk(2'd2, 4'h0, 8'd3,   1'b0, 4'd13, 3,   0,  4,   1'b0, 4'd0);
    vecs[9]  = mk(2'd2, 4'h0, 8'd20,  1'b1, 4'd0,  13,  0,  15,  1'b1, 4'd0);
    vecs[10] = mk(2'd1, 4'h0, 8'd255, 1'b0, 4'd15, 255, 0,  256, 1'b0, 4'd0);
    vecs[11] = mk(2'd1, 4'h0, 8'd1,   1'b1, 4'd15, 0,   0,  2,   1'b1, 4'd0);
    vecs[12] = mk(2'd2, 4'h0, 8'd16,  1'b0, 4'd15, 16,  0,  17,  1'b0, 4'd0);
    vecs[13] = mk(2'd1, 4'h0, 8'd0,   1'b1, 4'd15, 0,   0,  1,   1'b0, 4'd0);

    done_cnt = 0; acc_cnt = 0;
    for (int i = 0; i < 14; i++) run_cmd(vecs[i], 100 + i);
    check("max_flag_end", 114, int'(max_count), 1);

    // Random soak against the reference model.
    mcnt = 4'd15;
    for (int i = 0; i < 500; i++) begin
      logic [1:0] op;
      logic [3:0] d;
      logic [7:0] st;
      logic       se;
      vec_t       v;
      op = 2'($urandom_range(0, 3));
      d  = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
      se = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      v = model(op, d, st, se, mcnt);
      run_cmd(v, 1000 + i);
      mcnt = v.cnt;
    end

    check("done_vs_accepted", 2000, done_cnt, acc_cnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller placed directly upstream of the `counter` block. It accepts load, clear, and step commands over a valid/ready handshake and drives the counter's `load_n`, `ce`, `up_down` and `data_load` inputs. It observes the counter's `max_count` and `zero` flags, so it can optionally stop a step burst at the boundary instead of wrapping. Completion is reported with a one-cycle `done` pulse plus a saturation flag.

## Interface
- `WIDTH`, 4: counter data width; must match the attached `counter`.
- `STEP_W`, 8: width of the step-count field; bursts of up to 2^STEP_W−1 steps.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  2  operation: LOAD=0, UP=1, DOWN=2, CLEAR=3.
- `cmd_data`  in  WIDTH  load value (LOAD only).
- `cmd_steps`  in  STEP_W  number of `ce` cycles (UP/DOWN only).
- `cmd_sat_en`  in  1  stop at the boundary instead of wrapping (UP/DOWN only).
- `max_count`  in  1  from the counter; count is all ones.
- `zero`  in  1  from the counter; count is 0.
- `load_n`  out  1  to the counter; active-low load.
- `ce`  out  1  to the counter; count enable.
- `up_down`  out  1  to the counter; 1 = up.
- `data_load`  out  WIDTH  to the counter; load value.
- `busy`  out  1  a command is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle completion pulse.
- `sat`  out  1  valid only with `done`; 1 = the burst ended early at the boundary.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Handshake and capture:
  - `cmd_ready` = (state == IDLE).
  - A command is accepted on an edge where `cmd_valid && cmd_ready`.
  - Accepting latches `op`, `data`, `steps` and `sat_en` into registers.
- IDLE transitions on accept:
  - LOAD or CLEAR → LOAD.
  - UP or DOWN with `steps` ≠ 0 → RUN.
  - UP or DOWN with `steps` = 0 → DONE; no `ce` is issued.
- LOAD state (one cycle):
  - `load_n` = 0.
  - `data_load` = latched data for LOAD, 0 for CLEAR.
  - Next state: DONE.
- RUN state:
  - `up_down` = 1 for UP, 0 for DOWN.
  - `boundary` = UP ? `max_count` : `zero`.
  - `ce` = !(`sat_en` && `boundary`). This is combinational from the registered state and the counter flags; there is no loop, because the counter flags decode its count register.
  - When `ce` = 1: remaining-step register decrements. If remaining == 1, go to DONE with sat = 0.
  - When `ce` = 0 (boundary hit with `sat_en`): go to DONE with sat = 1.
- DONE state: `done` = 1, `sat` = the latched sat bit; next state IDLE.
- Wrap-around: with `sat_en` = 0 the counter wraps naturally (modulo 2^WIDTH); the sequencer does not intervene.
- Outputs outside LOAD/RUN: `load_n` = 1, `ce` = 0, `up_down` = 0, `data_load` = 0.
- Reset (asynchronous, any state including mid-RUN):
  - State → IDLE; all step and latch registers → 0.
  - Resulting outputs: `load_n` = 1, `ce` = 0, `up_down` = 0, `data_load` = 0, `busy` = 0, `done` = 0, `sat` = 0, `cmd_ready` = 1.
  - The counter's own reset is independent; the sequencer never drives it.

## Timing
- Command accepted at edge T0 → first drive cycle is T0..T1.
- LOAD/CLEAR:
  - `load_n` = 0 in cycle 1; the counter loads at edge T1.
  - `done` in cycle 2; `cmd_ready` returns in cycle 3.
- UP/DOWN with N steps and no saturation:
  - `ce` high in cycles 1..N.
  - `done` in cycle N+1; `cmd_ready` returns in cycle N+2.
- Saturating burst: `done` follows one cycle after the first cycle in which `ce` is suppressed.
- `steps` = 0: `done` in cycle 1.
- Back-to-back commands: minimum spacing is the cycle after DONE; there is no command queuing.

## Structure
- Package `counter_seq_pkg` holds:
  - `op_e` enum (LOAD, UP, DOWN, CLEAR).
  - `state_e` enum (IDLE, LOAD, RUN, DONE).
  - Default constants for `WIDTH` and `STEP_W`.
- Single module; the remaining-step down-counter stays inline. No sub-module is needed.
- The testbench pairs `counter_sequencer` with `counter` and checks against a golden model of the pair.

## Test plan
- **Reset mid-burst:** assert `rst` during RUN (UP, 10 steps, step 4) → same cycle `ce` = 0, `load_n` = 1, `busy` = 0, `cmd_ready` = 1; no `done`.
- **LOAD:** LOAD 4'hA → `load_n` = 0 for exactly one cycle with `data_load` = 10; `done` next cycle with `sat` = 0; counter = 10, `zero` = 0.
- **UP without saturation:** UP steps = 3 from 10 → `ce` high 3 cycles, counter = 13, `done` with `sat` = 0.
- **UP across the boundary:**
  - UP steps = 5, `sat_en` = 1 from 13 → `ce` high 2 cycles; counter = 15, `max_count` = 1; `done` with `sat` = 1.
  - Same burst with `sat_en` = 0 from 13 → counter wraps to 2; `sat` = 0.
- **Zero-step and saturation at start:**
  - DOWN steps = 0 → no `ce`; `done` in cycle 1.
  - CLEAR, then DOWN steps = 1 with `sat_en` = 1 → `ce` never asserts; counter stays 0; `done` with `sat` = 1.
- **Random soak:** 500 random commands with random `cmd_valid` gaps → counter output always matches the golden model; `done` count equals accepted-command count.
